// File: rtl/motoro3_pkg.sv
// Shared definitions for the 3-phase motor run-control sequencer.
//   state_e     : FSM state encoding exported on stateO (IDLE=0 .. FSTOP=6)
//   FREQ_*_DEF  : default frequency limits
//   clamp_freq  : saturates a requested frequency into [lo, hi]
package motoro3_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_RAMP  = 3'd2,
      ST_RUN   = 3'd3,
      ST_BRAKE = 3'd4,
      ST_COAST = 3'd5,
      ST_FSTOP = 3'd6
   } state_e;

   localparam int FREQ_W_DEF   = 10;
   localparam int FREQ_MIN_DEF = 1;
   localparam int FREQ_MAX_DEF = 1000;

   function automatic int clamp_freq(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/motoro3_tick_div.sv
// Prescaler: counts 0..DIV-1 while enabled and emits a 1-clk wrap strobe on
// the last count. clr_i (or a low enable) returns the count to 0.
//   clk_i  : clock
//   rst_i  : asynchronous reset, active-high
//   clr_i  : synchronous clear
//   en_i   : count enable
//   wrap_o : high on the clock where the count sits at DIV-1 (combinational)
module motoro3_tick_div #(
   parameter int DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic wrap_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // The strobe does not look at clr_i: the caller derives clr_i from its
   // next state, which itself depends on this strobe.
   assign wrap_o = en_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i)     cnt_d = '0;
      else if (cnt_q == LAST) cnt_d = '0;
      else                    cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/motoro3_run_sequencer.sv
// Run-control sequencer for the 3-phase motor datapath. Converts operator
// commands into start level, INC/DEC speed pulses, rotation direction and
// force-stop, ramping at one pulse per ramp tick and always reversing via
// ramp-down, coast, flip, ramp-up.
//   clkI, rstI        : clock, asynchronous active-high reset
//   cmdRunI           : level, request running
//   cmdStopI          : pulse, controlled stop
//   cmdForceStopI     : level, emergency stop (highest priority)
//   cmdDirI           : requested direction (0 fwd / 1 rev)
//   targetFreqI       : requested speed, clamped to [FREQ_MIN, FREQ_MAX]
//   m3startO          : datapath start level
//   m3freqINCo/DECo   : 1-clk speed pulses (registered)
//   m3invRotateO      : registered direction, only reloaded while start is low
//   m3forceStopO      : datapath force-stop
//   curFreqO          : shadow of datapath frequency
//   stateO            : FSM state encoding
//   atSpeedO          : running at the clamped target
module motoro3_run_sequencer
   import motoro3_pkg::*;
#(
   parameter int FREQ_W    = FREQ_W_DEF,
   parameter int FREQ_MIN  = FREQ_MIN_DEF,
   parameter int FREQ_MAX  = FREQ_MAX_DEF,
   parameter int RAMP_DIV  = 10000,
   parameter int COAST_CYC = 50000
) (
   input  logic              clkI,
   input  logic              rstI,
   input  logic              cmdRunI,
   input  logic              cmdStopI,
   input  logic              cmdForceStopI,
   input  logic              cmdDirI,
   input  logic [FREQ_W-1:0] targetFreqI,
   output logic              m3startO,
   output logic              m3freqINCo,
   output logic              m3freqDECo,
   output logic              m3invRotateO,
   output logic              m3forceStopO,
   output logic [FREQ_W-1:0] curFreqO,
   output logic [2:0]        stateO,
   output logic              atSpeedO
);

   localparam logic [FREQ_W-1:0] F_MIN = FREQ_W'(FREQ_MIN);
   localparam logic [FREQ_W-1:0] F_MAX = FREQ_W'(FREQ_MAX);

   state_e            state_q, state_d;
   logic [FREQ_W-1:0] cur_q, cur_d, tgt;
   logic              inc_q, inc_d, dec_q, dec_d;
   logic              inv_q, inv_d, dir_req_q, dir_req_d;
   logic              halt_q, halt_d, fs_ph_q, fs_ph_d;
   logic              ramp_tick, coast_done, st_chg, halt_req, dir_chg, at_min;

   assign tgt      = FREQ_W'(clamp_freq(int'(targetFreqI), FREQ_MIN, FREQ_MAX));
   assign halt_req = cmdStopI || !cmdRunI;
   assign dir_chg  = (cmdDirI != inv_q);
   assign at_min   = (cur_q <= F_MIN);
   assign st_chg   = (state_d != state_q);

   motoro3_tick_div #(.DIV(RAMP_DIV)) u_ramp_tick (
      .clk_i (clkI),
      .rst_i (rstI),
      .clr_i (st_chg),
      .en_i  ((state_q == ST_RAMP) || (state_q == ST_BRAKE)),
      .wrap_o(ramp_tick)
   );

   motoro3_tick_div #(.DIV(COAST_CYC)) u_coast_tmr (
      .clk_i (clkI),
      .rst_i (rstI),
      .clr_i (st_chg),
      .en_i  (state_q == ST_COAST),
      .wrap_o(coast_done)
   );

   // State register and datapath-control registers
   always_ff @(posedge clkI or posedge rstI) begin
      if (rstI) begin
         state_q   <= ST_IDLE;
         cur_q     <= F_MIN;
         inc_q     <= 1'b0;
         dec_q     <= 1'b0;
         inv_q     <= 1'b0;
         dir_req_q <= 1'b0;
         halt_q    <= 1'b0;
         fs_ph_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         inc_q     <= inc_d;
         dec_q     <= dec_d;
         inv_q     <= inv_d;
         dir_req_q <= dir_req_d;
         halt_q    <= halt_d;
         fs_ph_q   <= fs_ph_d;
      end
   end

   // Next state. halt_q records why BRAKE/COAST was entered: 1 = stop, 0 = flip.
   always_comb begin
      state_d   = state_q;
      halt_d    = halt_q;
      dir_req_d = dir_req_q;
      if (cmdForceStopI) begin
         state_d = ST_FSTOP;
      end else begin
         case (state_q)
            ST_IDLE: begin
               dir_req_d = cmdDirI;
               if (cmdRunI) state_d = ST_START;
            end
            ST_START: state_d = ST_RAMP;
            ST_RAMP, ST_RUN: begin
               if (halt_req) begin
                  state_d = ST_BRAKE;
                  halt_d  = 1'b1;
               end else if (dir_chg) begin
                  state_d   = ST_BRAKE;
                  halt_d    = 1'b0;
                  dir_req_d = cmdDirI;
               end else if ((state_q == ST_RAMP) && (cur_q == tgt)) begin
                  state_d = ST_RUN;
               end else if ((state_q == ST_RUN) && (cur_q != tgt)) begin
                  state_d = ST_RAMP;
               end
            end
            ST_BRAKE: begin
               dir_req_d = cmdDirI;
               if (halt_req) halt_d = 1'b1;
               if (at_min)   state_d = ST_COAST;
            end
            ST_COAST: begin
               dir_req_d = cmdDirI;
               if (halt_req) halt_d = 1'b1;
               // A flip whose requested direction went back to the current one
               // ends as a halt; IDLE restarts it if run is still requested.
               if (coast_done)
                  state_d = (!halt_d && (dir_req_d != inv_q)) ? ST_START : ST_IDLE;
            end
            ST_FSTOP: if (at_min) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Speed pulses, shadow frequency and direction reload
   always_comb begin
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      fs_ph_d = 1'b0;
      inv_d   = inv_q;
      if (state_q == ST_FSTOP) begin
         fs_ph_d = !fs_ph_q;
         dec_d   = fs_ph_q && !at_min;
      end else if (!cmdForceStopI) begin
         if ((state_q == ST_RAMP) && (state_d == ST_RAMP) && ramp_tick) begin
            inc_d = (cur_q < tgt) && (cur_q < F_MAX);
            dec_d = (cur_q > tgt) && !at_min;
         end else if ((state_q == ST_BRAKE) && ramp_tick) begin
            dec_d = !at_min;
         end
      end
      // Direction is loaded on entry to START, while start is still low.
      if ((state_d == ST_START) && (state_q != ST_START)) inv_d = dir_req_d;
      cur_d = cur_q;
      if (inc_d)      cur_d = cur_q + FREQ_W'(1);
      else if (dec_d) cur_d = cur_q - FREQ_W'(1);
   end

   // Outputs decoded from registered state
   always_comb begin
      m3startO     = (state_q == ST_START) || (state_q == ST_RAMP) ||
                     (state_q == ST_RUN)   || (state_q == ST_BRAKE);
      m3forceStopO = (state_q == ST_FSTOP);
      atSpeedO     = (state_q == ST_RUN) && (cur_q == tgt);
      m3freqINCo   = inc_q;
      m3freqDECo   = dec_q;
      m3invRotateO = inv_q;
      curFreqO     = cur_q;
      stateO       = state_q;
   end

endmodule

// File: tb/tb_motoro3_run_sequencer.sv
module tb_motoro3_run_sequencer;

   localparam int S_IDLE = 0, S_START = 1, S_RAMP = 2, S_RUN = 3;
   localparam int S_BRAKE = 4, S_COAST = 5, S_FSTOP = 6;

   logic       clk, rst, run, stop, fstop, dir;
   logic [9:0] tgt;
   logic       start, inc, dec, inv, fso, at_speed;
   logic [9:0] cur;
   logic [2:0] state;

   motoro3_run_sequencer #(
      .FREQ_W(10), .FREQ_MIN(1), .FREQ_MAX(1000), .RAMP_DIV(4), .COAST_CYC(8)
   ) dut (
      .clkI(clk), .rstI(rst), .cmdRunI(run), .cmdStopI(stop), .cmdForceStopI(fstop),
      .cmdDirI(dir), .targetFreqI(tgt), .m3startO(start), .m3freqINCo(inc),
      .m3freqDECo(dec), .m3invRotateO(inv), .m3forceStopO(fso), .curFreqO(cur),
      .stateO(state), .atSpeedO(at_speed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit is_dec;
      int freq;
      int gap;   // required clocks since previous pulse, 0 = not checked
   } pulse_t;

   pulse_t sb[$];
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic push_seq(input bit is_dec, input int from, input int to, input int gap);
      pulse_t p;
      int f;
      bit first;
      f = from;
      first = 1'b1;
      while (f != to) begin
         f = is_dec ? f - 1 : f + 1;
         p.is_dec = is_dec;
         p.freq   = f;
         p.gap    = first ? 0 : gap;
         sb.push_back(p);
         first = 1'b0;
      end
   endtask

   // Pulse monitor: pops the scoreboard whenever the DUT emits INC/DEC.
   int cyc = 0, last_cyc = 0;
   logic prev_start = 1'b0, prev_inv = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_start = 1'b0;
      end else begin
         cyc++;
         if (inc || dec) begin
            chk("inc_dec_excl", int'(inc & dec), 0);
            if (sb.size() == 0) begin
               chk("unexp_pulse", int'(cur), -1);
            end else begin
               pulse_t e;
               e = sb.pop_front();
               chk("pulse_is_dec", int'(dec), int'(e.is_dec));
               chk("pulse_freq", int'(cur), e.freq);
               if (e.gap != 0) chk("pulse_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
         end
         if (start && prev_start) chk("inv_hold", int'(inv), int'(prev_inv));
         prev_start = start;
         prev_inv   = inv;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_state(input int s, input int budget, input string tag);
      int n = 0;
      while (int'(state) != s && n < budget) begin
         step();
         n++;
      end
      chk(tag, int'(state), s);
   endtask

   task automatic wait_empty(input int budget, input string tag);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         step();
         n++;
      end
      chk(tag, sb.size(), 0);
      sb.delete();
   endtask

   task automatic count_state(input int s, input int exp, input string tag);
      int n = 0;
      while (int'(state) == s && n < 100) begin
         step();
         n++;
      end
      chk(tag, n, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; run = 1'b0; stop = 1'b0; fstop = 1'b0; dir = 1'b0; tgt = '0;
      repeat (3) step();
      chk("rst_state", int'(state), S_IDLE);
      chk("rst_start", int'(start), 0);
      chk("rst_inc", int'(inc), 0);
      chk("rst_dec", int'(dec), 0);
      chk("rst_inv", int'(inv), 0);
      chk("rst_fstop", int'(fso), 0);
      chk("rst_cur", int'(cur), 1);
      chk("rst_atspd", int'(at_speed), 0);
      rst = 1'b0;
      step();

      // 1: start-up ramp to 5
      push_seq(1'b0, 1, 5, 4);
      tgt = 10'd5; run = 1'b1;
      wait_state(S_START, 10, "t1_start_state");
      chk("t1_start_lvl", int'(start), 1);
      step();
      chk("t1_start_1clk", int'(state), S_RAMP);
      wait_empty(100, "t1_sb_empty");
      wait_state(S_RUN, 10, "t1_run");
      chk("t1_cur", int'(cur), 5);
      chk("t1_atspd", int'(at_speed), 1);
      chk("t1_start_hi", int'(start), 1);

      // 2: retargets, clamping at both ends
      push_seq(1'b1, 5, 2, 4);
      tgt = 10'd2;
      wait_empty(100, "t2_down_empty");
      wait_state(S_RUN, 10, "t2_run2");
      chk("t2_cur2", int'(cur), 2);
      push_seq(1'b1, 2, 1, 4);
      tgt = 10'd0;
      wait_empty(100, "t2_zero_empty");
      wait_state(S_RUN, 10, "t2_run1");
      chk("t2_cur1", int'(cur), 1);
      push_seq(1'b0, 1, 1000, 4);
      tgt = 10'd1023;
      wait_empty(5000, "t2_max_empty");
      wait_state(S_RUN, 10, "t2_runmax");
      repeat (20) step();
      chk("t2_curmax", int'(cur), 1000);
      chk("t2_atspd_max", int'(at_speed), 1);
      push_seq(1'b1, 1000, 5, 4);
      tgt = 10'd5;
      wait_empty(5000, "t2_back_empty");
      wait_state(S_RUN, 10, "t2_run5");

      // 3: direction reversal
      push_seq(1'b1, 5, 1, 4);
      push_seq(1'b0, 1, 5, 4);
      dir = 1'b1;
      wait_state(S_COAST, 100, "t3_coast");
      chk("t3_coast_start", int'(start), 0);
      count_state(S_COAST, 8, "t3_coast_len");
      chk("t3_restart", int'(state), S_START);
      chk("t3_inv", int'(inv), 1);
      wait_empty(100, "t3_sb_empty");
      wait_state(S_RUN, 10, "t3_run");
      chk("t3_cur", int'(cur), 5);

      // 4: controlled stop
      push_seq(1'b1, 5, 1, 4);
      stop = 1'b1;
      step();
      stop = 1'b0; run = 1'b0;
      wait_state(S_COAST, 100, "t4_coast");
      count_state(S_COAST, 8, "t4_coast_len");
      chk("t4_idle", int'(state), S_IDLE);
      repeat (20) step();
      chk("t4_still_idle", int'(state), S_IDLE);
      chk("t4_start", int'(start), 0);
      chk("t4_sb", sb.size(), 0);

      // 5: force-stop mid-ramp, INC due on the next clock must be dropped
      dir = 1'b0; tgt = 10'd5;
      push_seq(1'b0, 1, 3, 4);
      run = 1'b1;
      wait_empty(100, "t5_ramp_empty");
      repeat (3) step();
      push_seq(1'b1, 3, 1, 2);
      fstop = 1'b1;
      step();
      chk("t5_fstop_state", int'(state), S_FSTOP);
      chk("t5_fstop_out", int'(fso), 1);
      chk("t5_fstop_start", int'(start), 0);
      wait_empty(100, "t5_fs_empty");
      chk("t5_cur", int'(cur), 1);
      fstop = 1'b0; run = 1'b0;
      wait_state(S_IDLE, 10, "t5_idle");
      tgt = 10'd3;
      push_seq(1'b0, 1, 3, 4);
      run = 1'b1;
      wait_empty(100, "t5b_ramp_empty");
      wait_state(S_RUN, 10, "t5b_run");
      push_seq(1'b1, 3, 1, 2);
      fstop = 1'b1; stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t5b_fstop_wins", int'(state), S_FSTOP);
      wait_empty(100, "t5b_fs_empty");
      fstop = 1'b0; run = 1'b0;
      wait_state(S_IDLE, 10, "t5b_idle");

      // 6: asynchronous reset while running
      tgt = 10'd7;
      push_seq(1'b0, 1, 7, 4);
      run = 1'b1;
      wait_empty(100, "t6_ramp_empty");
      wait_state(S_RUN, 10, "t6_run");
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_start", int'(start), 0);
      chk("t6_inc", int'(inc), 0);
      chk("t6_dec", int'(dec), 0);
      chk("t6_fso", int'(fso), 0);
      chk("t6_atspd", int'(at_speed), 0);
      chk("t6_cur", int'(cur), 1);
      chk("t6_state", int'(state), S_IDLE);
      tgt = 10'd5;
      push_seq(1'b0, 1, 5, 4);
      step();
      step();
      rst = 1'b0;
      wait_state(S_START, 10, "t6_restart");
      chk("t6_restart_lvl", int'(start), 1);
      wait_empty(100, "t6_sb_empty");
      wait_state(S_RUN, 10, "t6_run5");
      chk("t6_cur5", int'(cur), 5);
      chk("t6_atspd5", int'(at_speed), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
